// File: rtl/op_prog_loader.sv
// Byte-serial program loader: assembles 21-bit op_codes from a framed byte stream
// and writes them into the node instruction RAM. Optional trailing checksum: OP_PROG_LOADER_CHECKSUM_EN.
module op_prog_loader #(
    parameter int ADDR_W    = 4,
    parameter int MAX_INSTR = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [20:0]       mem_wdata,
    output logic [ADDR_W:0]   prog_len,
    output logic              prog_valid,
    output logic              core_halt,
    output logic              load_done,
    output logic              load_err
);
`ifdef OP_PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, DONE, CHECK} state_t;
    localparam logic [7:0] CK_BYTES = 8'd1;
`else
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, DONE} state_t;
    localparam logic [7:0] CK_BYTES = 8'd0;
`endif
    localparam logic [7:0]  MAX_B = 8'(MAX_INSTR);
    localparam logic [ADDR_W:0] ONE = 1;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     n_q, n_d, idx_q, idx_d;
    logic [1:0]          phase_q, phase_d;
    logic [7:0]          b0_q, b0_d, b1_q, b1_d;
    logic [7:0]          rem_q, rem_d;
    logic                in_ready_q, in_ready_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [20:0]         mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]     prog_len_q, prog_len_d;
    logic                prog_valid_q, prog_valid_d, core_halt_q, core_halt_d;
    logic                load_done_q, load_done_d, load_err_q, load_err_d;
    logic                accept;
    logic [7:0]          words_left, drain_rem;
`ifdef OP_PROG_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    assign accept     = in_valid & in_ready_q;
    // Bytes still owed by the host after a rejected b2 (remaining words plus checksum).
    assign words_left = 8'(n_q) - 8'(idx_q) - 8'd1;
    assign drain_rem  = words_left * 8'd3 + CK_BYTES;

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        idx_d        = idx_q;
        phase_d      = phase_q;
        b0_d         = b0_q;
        b1_d         = b1_q;
        rem_d        = rem_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        prog_len_d   = prog_len_q;
        prog_valid_d = prog_valid_q;
        load_err_d   = 1'b0;
`ifdef OP_PROG_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
                if (in_data == 8'd0 || in_data > MAX_B) begin
                    load_err_d = 1'b1;
                end else begin
                    n_d          = in_data[ADDR_W:0];
                    idx_d        = '0;
                    phase_d      = 2'd0;
                    prog_valid_d = 1'b0;
                    state_d      = LOAD;
`ifdef OP_PROG_LOADER_CHECKSUM_EN
                    csum_d       = in_data;
`endif
                end
            end
            LOAD: if (accept) begin
`ifdef OP_PROG_LOADER_CHECKSUM_EN
                csum_d = csum_q ^ in_data;
`endif
                case (phase_q)
                    2'd0: begin b0_d = in_data; phase_d = 2'd1; end
                    2'd1: begin b1_d = in_data; phase_d = 2'd2; end
                    default: begin
                        phase_d = 2'd0;
                        if (in_data[7:5] == 3'b000) begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = idx_q[ADDR_W-1:0];
                            mem_wdata_d = {in_data[4:0], b1_q, b0_q};
                            idx_d       = idx_q + ONE;
                            if (idx_q == n_q - ONE) begin
`ifdef OP_PROG_LOADER_CHECKSUM_EN
                                state_d = CHECK;
`else
                                state_d = DONE;
`endif
                            end
                        end else begin
                            load_err_d = 1'b1;
                            prog_len_d = '0;
                            rem_d      = drain_rem;
                            // Nothing left to swallow if the bad byte closed the frame.
                            state_d    = (drain_rem == 8'd0) ? IDLE : DRAIN;
                        end
                    end
                endcase
            end
            DRAIN: if (accept) begin
                rem_d = rem_q - 8'd1;
                if (rem_q == 8'd1) state_d = IDLE;
            end
`ifdef OP_PROG_LOADER_CHECKSUM_EN
            CHECK: if (accept) begin
                if (in_data == csum_q) begin
                    state_d = DONE;
                end else begin
                    load_err_d = 1'b1;
                    prog_len_d = '0;
                    state_d    = IDLE;
                end
            end
`endif
            DONE: begin
                prog_len_d   = n_q;
                prog_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d != DONE);
        load_done_d = (state_d == DONE);
        core_halt_d = ~prog_valid_d | (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            n_q          <= '0;
            idx_q        <= '0;
            phase_q      <= 2'd0;
            b0_q         <= 8'd0;
            b1_q         <= 8'd0;
            rem_q        <= 8'd0;
            in_ready_q   <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            prog_len_q   <= '0;
            prog_valid_q <= 1'b0;
            core_halt_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
`ifdef OP_PROG_LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            phase_q      <= phase_d;
            b0_q         <= b0_d;
            b1_q         <= b1_d;
            rem_q        <= rem_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            prog_len_q   <= prog_len_d;
            prog_valid_q <= prog_valid_d;
            core_halt_q  <= core_halt_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
`ifdef OP_PROG_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign prog_len   = prog_len_q;
    assign prog_valid = prog_valid_q;
    assign core_halt  = core_halt_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
endmodule

// File: tb/tb_op_prog_loader.sv
// Directed bench for op_prog_loader: frame loads, header/b2 rejects, stalls, mid-frame reset.
module tb_op_prog_loader;
    logic        clk, rst_n, in_valid, in_ready, mem_we, prog_valid, core_halt, load_done, load_err;
    logic [7:0]  in_data;
    logic [3:0]  mem_addr;
    logic [20:0] mem_wdata;
    logic [4:0]  prog_len;

    int total = 0, bad = 0;
    int n_done = 0, n_err = 0, n_rdy_bad = 0;
    logic after_done = 0, halt_after = 1;
    logic [3:0]  wa[$];
    logic [20:0] wd[$];
    logic [7:0]  frm[$];

    op_prog_loader #(.ADDR_W(4), .MAX_INSTR(15)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .prog_len(prog_len),
        .prog_valid(prog_valid), .core_halt(core_halt), .load_done(load_done), .load_err(load_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin wa.push_back(mem_addr); wd.push_back(mem_wdata); end
            if (load_done) n_done++;
            if (load_err) n_err++;
            if (!in_ready && !load_done) n_rdy_bad++;
            if (after_done) halt_after = core_halt;
            after_done = load_done;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); n_done = 0; n_err = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        logic acc = 0;
        in_data = b; in_valid = 1;
        while (!acc && n < 50) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_frame(input bit stall);
        logic [7:0] x = 8'd0;
        foreach (frm[i]) x = x ^ frm[i];
`ifdef OP_PROG_LOADER_CHECKSUM_EN
        frm.push_back(x);
`endif
        foreach (frm[i]) begin
            if (stall) idle($urandom_range(0, 3));
            send_byte(frm[i]);
        end
        idle(4);
    endtask

    task automatic chk_wr(input string tag, input int i, input logic [3:0] a, input logic [20:0] d);
        chk({tag, "_present"}, 32'(wa.size() > i), 32'd1);
        if (wa.size() > i) begin
            chk({tag, "_addr"}, 32'(wa[i]), 32'(a));
            chk({tag, "_data"}, 32'(wd[i]), 32'(d));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_prog_len"}, 32'(prog_len), 32'd0);
        chk({tag, "_prog_valid"}, 32'(prog_valid), 32'd0);
        chk({tag, "_core_halt"}, 32'(core_halt), 32'd1);
        chk({tag, "_load_done"}, 32'(load_done), 32'd0);
        chk({tag, "_load_err"}, 32'(load_err), 32'd0);
    endtask

    task automatic chk_three(input string tag);
        chk({tag, "_nwr"}, 32'(wa.size()), 32'd3);
        chk_wr({tag, "_w0"}, 0, 4'd0, 21'h032211);
        chk_wr({tag, "_w1"}, 1, 4'd1, 21'h065544);
        chk_wr({tag, "_w2"}, 2, 4'd2, 21'h198877);
        chk({tag, "_done"}, 32'(n_done), 32'd1);
        chk({tag, "_len"}, 32'(prog_len), 32'd3);
        chk({tag, "_valid"}, 32'(prog_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; in_valid = 0; in_data = 0;
        #12;
        chk_reset_vals("reset");
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        // Two-word frame, back to back.
        clear_log();
        frm = '{8'h02, 8'h34, 8'h12, 8'h01, 8'hFF, 8'hFF, 8'h1F};
        send_frame(0);
        chk("f1_nwr", 32'(wa.size()), 32'd2);
        chk_wr("f1_w0", 0, 4'd0, 21'h011234);
        chk_wr("f1_w1", 1, 4'd1, 21'h1FFFFF);
        chk("f1_done", 32'(n_done), 32'd1);
        chk("f1_err", 32'(n_err), 32'd0);
        chk("f1_len", 32'(prog_len), 32'd2);
        chk("f1_valid", 32'(prog_valid), 32'd1);
        chk("f1_halt_after_done", 32'(halt_after), 32'd0);
        chk("f1_halt_idle", 32'(core_halt), 32'd0);

        // Out-of-range headers leave the resident program alone.
        clear_log();
        send_byte(8'h00); idle(2);
        send_byte(8'h10); idle(3);
        chk("hdr_err", 32'(n_err), 32'd2);
        chk("hdr_nwr", 32'(wa.size()), 32'd0);
        chk("hdr_len", 32'(prog_len), 32'd2);
        chk("hdr_valid", 32'(prog_valid), 32'd1);
        chk("hdr_halt", 32'(core_halt), 32'd0);

        // Illegal upper bits in b2.
        clear_log();
        frm = '{8'h01, 8'h00, 8'h00, 8'h20};
        send_frame(0);
        chk("b2_nwr", 32'(wa.size()), 32'd0);
        chk("b2_err", 32'(n_err), 32'd1);
        chk("b2_valid", 32'(prog_valid), 32'd0);
        chk("b2_len", 32'(prog_len), 32'd0);
        chk("b2_halt", 32'(core_halt), 32'd1);
        clear_log();
        frm = '{8'h01, 8'h05, 8'h00, 8'h00};
        send_frame(0);
        chk("rec_nwr", 32'(wa.size()), 32'd1);
        chk_wr("rec_w0", 0, 4'd0, 21'h000005);
        chk("rec_len", 32'(prog_len), 32'd1);
        chk("rec_valid", 32'(prog_valid), 32'd1);

        // Three-word frame unstalled, then with random gaps on in_valid.
        clear_log();
        frm = '{8'h03, 8'h11, 8'h22, 8'h03, 8'h44, 8'h55, 8'h06, 8'h77, 8'h88, 8'h19};
        send_frame(0);
        chk_three("s0");
        clear_log();
        frm = '{8'h03, 8'h11, 8'h22, 8'h03, 8'h44, 8'h55, 8'h06, 8'h77, 8'h88, 8'h19};
        send_frame(1);
        chk_three("s1");

        // Reset lands after header plus one full word.
        clear_log();
        send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h03);
        in_valid = 0;
        rst_n = 0;
        #2;
        chk_reset_vals("midrst");
        @(posedge clk); @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        clear_log();
        frm = '{8'h03, 8'h11, 8'h22, 8'h03, 8'h44, 8'h55, 8'h06, 8'h77, 8'h88, 8'h19};
        send_frame(0);
        chk_three("postrst");

`ifdef OP_PROG_LOADER_CHECKSUM_EN
        // Checksum covers the header byte too: 01^34^12^01 = 26.
        clear_log();
        send_byte(8'h01); send_byte(8'h34); send_byte(8'h12); send_byte(8'h01); send_byte(8'h26);
        idle(4);
        chk("ck_good_done", 32'(n_done), 32'd1);
        chk("ck_good_len", 32'(prog_len), 32'd1);
        clear_log();
        send_byte(8'h01); send_byte(8'h34); send_byte(8'h12); send_byte(8'h01); send_byte(8'h27);
        idle(4);
        chk("ck_bad_err", 32'(n_err), 32'd1);
        chk("ck_bad_done", 32'(n_done), 32'd0);
        chk("ck_bad_valid", 32'(prog_valid), 32'd0);
        chk("ck_bad_len", 32'(prog_len), 32'd0);
`endif

        chk("ready_low_only_done", 32'(n_rdy_bad), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
